// File: rtl/ud_counter_param_if.sv
// Control and status bundle for ud_counter_param. The flag signal is named sat instead of wrap
// when UD_COUNTER_SATURATE_EN is defined.
interface ud_counter_param_if #(
    parameter int unsigned WIDTH = 4
) ();
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
`ifdef UD_COUNTER_SATURATE_EN
    logic             sat;
`else
    logic             wrap;
`endif
    logic             at_zero;
    logic             at_max;

`ifdef UD_COUNTER_SATURATE_EN
    modport master (output en, up, load, load_val, input count, sat, at_zero, at_max);
    modport slave  (input en, up, load, load_val, output count, sat, at_zero, at_max);
`else
    modport master (output en, up, load, load_val, input count, wrap, at_zero, at_max);
    modport slave  (input en, up, load, load_val, output count, wrap, at_zero, at_max);
`endif
endinterface

// File: rtl/ud_counter_param.sv
// Parametrised up/down counter with modulus MAX_VAL+1, load clamp and a registered wrap pulse.
// Define UD_COUNTER_SATURATE_EN to saturate at the bounds and report blocked steps on sat.
module ud_counter_param #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_VAL   = 15,
    parameter int unsigned RESET_VAL = 0
) (
    input logic               clk,
    input logic               reset,
    ud_counter_param_if.slave bus
);
    localparam logic [WIDTH-1:0] MaxVal   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VAL);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("ud_counter_param: WIDTH must be in 2..32");
    end
    if (MAX_VAL < 1 || 64'(MAX_VAL) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_max
        $error("ud_counter_param: MAX_VAL must be in 1..2^WIDTH-1");
    end
    if (RESET_VAL > MAX_VAL) begin : g_bad_reset
        $error("ud_counter_param: RESET_VAL must not exceed MAX_VAL");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             flag_q, flag_d;

    always_comb begin
        count_d = count_q;
        flag_d  = 1'b0;
        if (bus.load) begin
            count_d = (bus.load_val > MaxVal) ? MaxVal : bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                if (count_q == MaxVal) begin
                    flag_d = 1'b1;
`ifdef UD_COUNTER_SATURATE_EN
                    count_d = MaxVal;
`else
                    count_d = '0;
`endif
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    flag_d = 1'b1;
`ifdef UD_COUNTER_SATURATE_EN
                    count_d = '0;
`else
                    count_d = MaxVal;
`endif
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= ResetVal;
            flag_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q  <= flag_d;
        end
    end

    assign bus.count   = count_q;
`ifdef UD_COUNTER_SATURATE_EN
    assign bus.sat     = flag_q;
`else
    assign bus.wrap    = flag_q;
`endif
    assign bus.at_zero = (count_q == '0);
    assign bus.at_max  = (count_q == MaxVal);
endmodule

// File: tb/tb_ud_counter_param.sv
// Bench for ud_counter_param: directed vector table, a toggle sequence at the lower bound and
// randomized traffic against an arithmetic model, on a modulus-16 and a modulus-10 instance.
module tb_ud_counter_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic flag_a, flag_b;

    ud_counter_param_if #(.WIDTH(4)) if_a ();
    ud_counter_param_if #(.WIDTH(4)) if_b ();

    ud_counter_param #(.WIDTH(4), .MAX_VAL(15), .RESET_VAL(0)) dut_a (
        .clk  (clk),
        .reset(rst_a),
        .bus  (if_a)
    );
    ud_counter_param #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(3)) dut_b (
        .clk  (clk),
        .reset(rst_b),
        .bus  (if_b)
    );

`ifdef UD_COUNTER_SATURATE_EN
    assign flag_a = if_a.sat;
    assign flag_b = if_b.sat;
`else
    assign flag_a = if_a.wrap;
    assign flag_b = if_b.wrap;
`endif

    typedef struct {
        string      name;
        int         d;
        logic       r, e, u, l;
        logic [3:0] lv;
        logic [3:0] c;
        logic       f;
    } vec_t;

    vec_t        vecs[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [3:0]  m_cnt  [2];
    logic        m_flag [2];

    task automatic add(input string nm, input int d, input logic r, e, u, l,
                       input logic [3:0] lv, input logic [3:0] c, input logic f);
        vec_t v;
        v.name = nm; v.d = d; v.r = r; v.e = e; v.u = u; v.l = l;
        v.lv = lv; v.c = c; v.f = f;
        vecs.push_back(v);
    endtask

    task automatic set_in(input int d, input logic r, e, u, l, input logic [3:0] lv);
        if (d == 0) begin
            rst_a = r; if_a.en = e; if_a.up = u; if_a.load = l; if_a.load_val = lv;
        end else begin
            rst_b = r; if_b.en = e; if_b.up = u; if_b.load = l; if_b.load_val = lv;
        end
    endtask

    // Drive one instance for a single edge while the other holds.
    task automatic step(input int d, input logic r, e, u, l, input logic [3:0] lv);
        @(negedge clk);
        set_in(1 - d, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        set_in(d, r, e, u, l, lv);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int d, input logic [3:0] ec, input logic ef);
        logic [3:0] c;
        logic       f, z, m, ez, em;
        if (d == 0) begin
            c = if_a.count; f = flag_a; z = if_a.at_zero; m = if_a.at_max;
        end else begin
            c = if_b.count; f = flag_b; z = if_b.at_zero; m = if_b.at_max;
        end
        ez = (ec == 4'd0);
        em = (ec == ((d == 0) ? 4'd15 : 4'd9));
        n_tests++;
        if (c !== ec || f !== ef || z !== ez || m !== em) begin
            n_fail++;
            $display("FAIL %s dut%0d: got count=%0d flag=%b zero=%b max=%b, want count=%0d flag=%b zero=%b max=%b",
                     nm, d, c, f, z, m, ec, ef, ez, em);
        end
    endtask

    // Reference: modular arithmetic over 0..MAX_VAL, or clipping when saturating.
    task automatic model_step(input int d, input logic r, e, u, l, input logic [3:0] lv);
        int mx, nxt;
        mx = (d == 0) ? 15 : 9;
        m_flag[d] = 1'b0;
        if (r) begin
            m_cnt[d] = (d == 0) ? 4'd0 : 4'd3;
        end else if (l) begin
            m_cnt[d] = (int'(lv) > mx) ? 4'(mx) : lv;
        end else if (e) begin
            nxt = u ? int'(m_cnt[d]) + 1 : int'(m_cnt[d]) - 1;
            if (nxt < 0 || nxt > mx) begin
                m_flag[d] = 1'b1;
`ifdef UD_COUNTER_SATURATE_EN
                nxt = (nxt < 0) ? 0 : mx;
`else
                nxt = (nxt + mx + 1) % (mx + 1);
`endif
            end
            m_cnt[d] = 4'(nxt);
        end
    endtask

    initial begin
        logic [3:0] hc [5];
        logic       hf [5];
        logic       rr, re, ru, rl;
        logic [3:0] rlv;

        set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        set_in(1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

`ifdef UD_COUNTER_SATURATE_EN
        add("rst", 0, 1, 0, 0, 0, 0, 0, 0);
        add("load14", 0, 0, 0, 0, 1, 14, 14, 0);
        add("sat_up1", 0, 0, 1, 1, 0, 0, 15, 0);
        add("sat_up2", 0, 0, 1, 1, 0, 0, 15, 1);
        add("sat_up3", 0, 0, 1, 1, 0, 0, 15, 1);
        add("sat_hold", 0, 0, 0, 0, 0, 0, 15, 0);
        add("load0", 0, 0, 0, 0, 1, 0, 0, 0);
        add("sat_dn1", 0, 0, 1, 0, 0, 0, 0, 1);
        add("sat_hold0", 0, 0, 0, 0, 0, 0, 0, 0);
        add("rst_b", 1, 1, 0, 0, 0, 0, 3, 0);
        add("clamp12_b", 1, 0, 0, 0, 1, 12, 9, 0);
        add("sat_up_b", 1, 0, 1, 1, 0, 0, 9, 1);
        add("dn_b", 1, 0, 1, 0, 0, 0, 8, 0);
        hc = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd0};
        hf = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`else
        add("rst1", 0, 1, 0, 0, 0, 0, 0, 0);
        add("rst2", 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add("hold", 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) add("up_seq", 0, 0, 1, 1, 0, 0, 4'(i % 16), i == 16);
        add("wrap_ends", 0, 0, 0, 0, 0, 0, 0, 0);
        add("load6", 0, 0, 0, 0, 1, 6, 6, 0);
        add("up7", 0, 0, 1, 1, 0, 0, 7, 0);
        add("rst_over_load", 0, 1, 1, 1, 1, 9, 0, 0);
        add("load5", 0, 0, 0, 0, 1, 5, 5, 0);
        add("tog_up", 0, 0, 1, 1, 0, 0, 6, 0);
        add("tog_dn", 0, 0, 1, 0, 0, 0, 5, 0);
        add("tog_up", 0, 0, 1, 1, 0, 0, 6, 0);
        add("tog_dn", 0, 0, 1, 0, 0, 0, 5, 0);
        add("load15", 0, 0, 0, 0, 1, 15, 15, 0);
        add("rst_over_wrap", 0, 1, 1, 1, 0, 0, 0, 0);
        add("load0", 0, 0, 0, 0, 1, 0, 0, 0);
        add("dn_wrap16", 0, 0, 1, 0, 0, 0, 15, 1);
        add("dn16", 0, 0, 1, 0, 0, 0, 14, 0);
        add("rst_b", 1, 1, 0, 0, 0, 0, 3, 0);
        add("hold_b", 1, 0, 0, 0, 0, 0, 3, 0);
        add("load0_b", 1, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 11; i++)
            add("dn_seq10", 1, 0, 1, 0, 0, 0, (i == 11) ? 4'd9 : 4'(10 - i), (i == 1) || (i == 11));
        add("load4", 1, 0, 0, 0, 1, 4, 4, 0);
        add("clamp12_en", 1, 0, 1, 1, 1, 12, 9, 0);
        add("load3_en", 1, 0, 1, 1, 1, 3, 3, 0);
        add("clamp10", 1, 0, 0, 0, 1, 10, 9, 0);
        add("up_wrap10", 1, 0, 1, 1, 0, 0, 0, 1);
        add("wrap_ends_b", 1, 0, 0, 0, 0, 0, 0, 0);
        add("load9", 1, 0, 0, 0, 1, 9, 9, 0);
        add("load_over_wrap", 1, 0, 1, 1, 1, 9, 9, 0);
        add("clamp15", 1, 0, 0, 1, 1, 15, 9, 0);
        hc = '{4'd0, 4'd9, 4'd0, 4'd9, 4'd9};
        hf = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`endif

        foreach (vecs[i]) begin
            step(vecs[i].d, vecs[i].r, vecs[i].e, vecs[i].u, vecs[i].l, vecs[i].lv);
            check(vecs[i].name, vecs[i].d, vecs[i].c, vecs[i].f);
        end

        // Direction flips at the lower bound of the modulus-10 instance.
        step(1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        check("bound_load0", 1, hc[0], hf[0]);
        step(1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check("bound_dn", 1, hc[1], hf[1]);
        step(1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        check("bound_up", 1, hc[2], hf[2]);
        step(1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check("bound_dn2", 1, hc[3], hf[3]);
        step(1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        check("bound_hold", 1, hc[4], hf[4]);

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                rr  = (n == 0) || ($urandom_range(0, 31) == 0);
                rl  = ($urandom_range(0, 5) == 0);
                re  = ($urandom_range(0, 3) != 0);
                ru  = 1'($urandom);
                rlv = 4'($urandom_range(0, 15));
                set_in(d, rr, re, ru, rl, rlv);
                model_step(d, rr, re, ru, rl, rlv);
            end
            @(posedge clk);
            #1;
            check("random", 0, m_cnt[0], m_flag[0]);
            check("random", 1, m_cnt[1], m_flag[1]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ud_counter_param.md
Name: ud_counter_param

Overview:
- Parametrised synchronous up/down counter, the next generation of the team's 4-bit up/down counter.
- Adds configurable width and modulus, count enable, parallel load, a registered wrap pulse and combinational zero/max flags.
- Used as a general event counter, address sequencer and timebase in datapath blocks.
- All state changes on the rising clk edge only; no input acts asynchronously.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..32).
- MAX_VAL, 15, terminal count; the count range is 0..MAX_VAL. Must satisfy 1 <= MAX_VAL <= 2^WIDTH-1.
- RESET_VAL, 0, value loaded on reset. Must be <= MAX_VAL.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; the counter holds when low.
- up  in  1  direction: 1 = count up, 0 = count down. Sampled only at the clk edge.
- load  in  1  synchronous parallel load request.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  registered counter value.
- wrap  out  1  registered one-cycle pulse, high in the cycle after a wrap occurred.
- at_zero  out  1  combinational, high when count == 0.
- at_max  out  1  combinational, high when count == MAX_VAL.

Behaviour:
- Reset is reset, synchronous, active-high; clock is clk.
- Reset values: count = RESET_VAL, wrap = 0. at_zero and at_max follow from count.
- Priority per clk edge: reset > load > en. When none of these is active, count holds.
- Load:
  - count <= load_val when load_val <= MAX_VAL, otherwise count <= MAX_VAL (clamp).
  - wrap <= 0.
  - load takes effect regardless of en.
- Up count (en=1, up=1):
  - count < MAX_VAL: count <= count + 1, wrap <= 0.
  - count == MAX_VAL: count <= 0, wrap <= 1.
- Down count (en=1, up=0):
  - count > 0: count <= count - 1, wrap <= 0.
  - count == 0: count <= MAX_VAL, wrap <= 1.
- Hold (en=0, no load, no reset): count is unchanged and wrap <= 0. A wrap pulse therefore lasts exactly one cycle.
- Arithmetic: the increment and decrement never exceed the WIDTH bits; the wrap comparison is against MAX_VAL, not 2^WIDTH-1.
- Direction change: up may toggle on any cycle. The next edge uses the new direction and there is no dead cycle.
- Latency: count reflects a command one clk edge after it is sampled. wrap is aligned to the same edge at which count takes its wrapped value.
- Reset mid-operation: overrides load and en on that edge. The following cycle shows count = RESET_VAL and wrap = 0.
- Out-of-range state cannot occur: load clamps, and the parameter constraints prevent it. Parameter violations are flagged by an elaboration-time check.

Optional Feature:
- Macro: UD_COUNTER_SATURATE_EN.
- Defined:
  - The counter saturates instead of wrapping.
  - Up at MAX_VAL holds MAX_VAL; down at 0 holds 0.
  - wrap is replaced by sat, a registered one-cycle pulse, high when a count request was blocked at a bound.
  - Load clamping is unchanged.
- Not defined: the wrap-around behaviour above applies, and the port is named wrap.

Test Plan:
1. Reset and hold: WIDTH=4, MAX_VAL=15, assert reset for 2 cycles -> count=0, wrap=0, at_zero=1. Then en=0 for 5 cycles -> count stays 0.
2. Up wrap: en=1, up=1 from 0 for 16 edges -> count steps 1..15 then 0. wrap=1 only in the cycle count returns to 0. at_max=1 while count=15.
3. Down wrap with non-power-of-two modulus: MAX_VAL=9, load 0, then en=1, up=0 -> count 9,8,...,0,9. wrap pulses on each 0->9 transition.
4. Load priority and clamp: MAX_VAL=9, count=4, en=1, load=1, load_val=12 -> count=9 next cycle. Then load_val=3 with en=1 -> count=3, not 4 or 5.
5. Mid-run control: counting up at count=7, assert reset and load together -> count=RESET_VAL (0). Toggle up each cycle from 5 -> 6,5,6,5.
6. With UD_COUNTER_SATURATE_EN, MAX_VAL=15: count up from 14 for 3 edges -> 15,15,15, with sat=1 on the 2nd and 3rd edges. Count down from 0 -> stays 0 with sat=1.
